// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: shares one registered output channel between
// CHANNELS valid/ready requesters and holds the grant for a whole packet.
module rr_packet_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [WIDTH*CHANNELS-1:0]     in,
  input  logic [CHANNELS-1:0]           in_valid,
  input  logic [CHANNELS-1:0]           in_last,
  output logic [CHANNELS-1:0]           in_ready,
  output logic [$clog2(CHANNELS)-1:0]   sel,
  output logic [WIDTH-1:0]              out,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned PW = $clog2(CHANNELS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;

  logic            can_accept_c;
  logic            win_found_c;
  logic [PW-1:0]   win_ch_c;
  logic            grant_en_c;
  logic [PW-1:0]   grant_ch_c;
  logic            grant_valid_c;
  logic            grant_last_c;
  logic [WIDTH-1:0] grant_data_c;
  logic            xfer_c;

  // Wrap-around successor of a channel index; never leaves 0..CHANNELS-1.
  function automatic logic [PW-1:0] next_ch(input logic [PW-1:0] c);
    return (c == PW'(CHANNELS - 1)) ? '0 : c + PW'(1);
  endfunction

  // Round-robin winner: first valid channel at or above ptr, else lowest below it.
  always_comb begin
    win_found_c = 1'b0;
    win_ch_c    = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (!win_found_c && in_valid[i] && (PW'(i) >= ptr_q)) begin
        win_found_c = 1'b1;
        win_ch_c    = PW'(i);
      end
    end
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (!win_found_c && in_valid[i] && (PW'(i) < ptr_q)) begin
        win_found_c = 1'b1;
        win_ch_c    = PW'(i);
      end
    end
  end

  // Next-state, handshake and output-register logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    out_d         = out_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q;
    grant_en_c    = 1'b0;
    grant_ch_c    = sel_q;
    grant_valid_c = 1'b0;
    grant_last_c  = 1'b0;
    grant_data_c  = '0;
    in_ready      = '0;

    can_accept_c = !out_valid_q || out_ready;

    case (state_q)
      IDLE: begin
        grant_en_c = enable && win_found_c;
        grant_ch_c = win_ch_c;
      end
      LOCKED: begin
        grant_en_c = 1'b1;
        grant_ch_c = sel_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing is offered while reset is being sampled.
    if (reset) begin
      grant_en_c = 1'b0;
    end

    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (PW'(i) == grant_ch_c) begin
        grant_valid_c = in_valid[i];
        grant_last_c  = in_last[i];
        grant_data_c  = in[i*WIDTH +: WIDTH];
        in_ready[i]   = grant_en_c && can_accept_c;
      end
    end

    xfer_c = grant_en_c && can_accept_c && grant_valid_c;

    if (xfer_c) begin
      out_d       = grant_data_c;
      out_last_d  = grant_last_c;
      out_valid_d = 1'b1;
      sel_d       = grant_ch_c;
      if (grant_last_c) begin
        state_d = IDLE;
        ptr_d   = next_ch(grant_ch_c);
      end else begin
        state_d = LOCKED;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State, pointer and output registers; reset overrides every update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign out       = out_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomized and directed bench for rr_packet_arbiter against a packet-level model.
module tb_rr_packet_arbiter;

  localparam int C = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           en;
  logic [C*W-1:0] din;
  logic [C-1:0]   dvalid;
  logic [C-1:0]   dlast;
  logic [C-1:0]   rdy;
  logic [1:0]     dsel;
  logic [W-1:0]   dout;
  logic           dout_last;
  logic           dout_valid;
  logic           dout_ready;

  int checks;
  int failures;

  // Reference model state
  int       m_ptr;
  bit       m_locked;
  int       m_lch;
  logic [7:0] m_out;
  bit       m_last;
  bit       m_valid;
  int       m_sel;

  rr_packet_arbiter #(.CHANNELS(C), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (rst),
    .enable    (en),
    .in        (din),
    .in_valid  (dvalid),
    .in_last   (dlast),
    .in_ready  (rdy),
    .sel       (dsel),
    .out       (dout),
    .out_last  (dout_last),
    .out_valid (dout_valid),
    .out_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which requester may move a beat this cycle, from the arbitration rules.
  function automatic logic [C-1:0] model_ready();
    bit can;
    can = !m_valid || (dout_ready == 1'b1);
    if (rst) return '0;
    if (m_locked) return can ? C'(1 << m_lch) : '0;
    if (!en) return '0;
    for (int k = 0; k < C; k++) begin
      int idx;
      idx = (m_ptr + k) % C;
      if (((dvalid >> idx) & 1) != 0) return can ? C'(1 << idx) : '0;
    end
    return '0;
  endfunction

  // One clock: check handshake mid-cycle, advance model at the edge, check outputs after.
  task automatic tick();
    logic [C-1:0] er;
    logic [C-1:0] acc;
    @(negedge clk);
    er = model_ready();
    check("in_ready", 32'(rdy), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_locked = 0; m_lch = 0;
      m_out = 0; m_last = 0; m_valid = 0; m_sel = 0;
    end else begin
      acc = er & dvalid;
      if (acc != 0) begin
        int ch;
        ch = 0;
        for (int i = 0; i < C; i++) if (((acc >> i) & 1) != 0) ch = i;
        m_out   = 8'(din >> (ch * W));
        m_last  = ((dlast >> ch) & 1) != 0;
        m_valid = 1;
        m_sel   = ch;
        if (m_last) begin
          m_locked = 0;
          m_ptr    = (ch + 1) % C;
        end else begin
          m_locked = 1;
          m_lch    = ch;
        end
      end else if (dout_ready) begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", 32'(dout_valid), 32'(m_valid));
    check("out", 32'(dout), 32'(m_out));
    check("out_last", 32'(dout_last), 32'(m_last));
    check("sel", 32'(dsel), 32'(m_sel));
  endtask

  task automatic set_ch(input int c, input bit v, input bit l, input logic [7:0] d);
    dvalid = (dvalid & ~C'(1 << c)) | (C'(v) << c);
    dlast  = (dlast & ~C'(1 << c)) | (C'(l) << c);
    din    = (din & ~(32'hFF << (c * W))) | (32'(d) << (c * W));
  endtask

  task automatic clear_all();
    dvalid = '0;
    dlast  = '0;
    din    = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_ptr = 0; m_locked = 0; m_lch = 0;
    m_out = 0; m_last = 0; m_valid = 0; m_sel = 0;
    rst = 1'b1; en = 1'b1; dout_ready = 1'b1;
    din = 32'h01020304; dvalid = 4'b1111; dlast = 4'b1111;

    // Reset held with every requester active
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rst_out", 32'(dout), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
    end

    // Round robin with single-beat packets: out 4,3,2,1 and sel 0..3
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("rr_out", 32'(dout), 32'(4 - (n % 4)));
      check("rr_sel", 32'(dsel), 32'(n % 4));
    end

    // Packet lock on channel 2 while channel 0 waits
    clear_all();
    set_ch(2, 1, 0, 8'hA0);
    tick();
    check("lock_a0", 32'(dout), 32'hA0);
    set_ch(2, 1, 0, 8'hA1);
    set_ch(0, 1, 1, 8'h55);
    #1 check("lock_rdy0", 32'(rdy[0]), 32'h0);
    tick();
    check("lock_a1", 32'(dout), 32'hA1);
    set_ch(2, 1, 1, 8'hA2);
    #1 check("lock_rdy0b", 32'(rdy[0]), 32'h0);
    tick();
    check("lock_a2", 32'(dout), 32'hA2);
    set_ch(2, 0, 0, 8'h00);
    tick();
    check("lock_after", 32'(dout), 32'h55);
    check("lock_after_sel", 32'(dsel), 32'h0);

    // Backpressure mid-packet on channel 1
    clear_all();
    set_ch(1, 1, 0, 8'hB0);
    tick();
    check("bp_b0", 32'(dout), 32'hB0);
    set_ch(1, 1, 0, 8'hB1);
    dout_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1 check("bp_rdy", 32'(rdy), 32'h0);
      tick();
      check("bp_hold", 32'(dout), 32'hB0);
      check("bp_hold_v", 32'(dout_valid), 32'h1);
    end
    dout_ready = 1'b1;
    tick();
    check("bp_b1", 32'(dout), 32'hB1);
    set_ch(1, 1, 1, 8'hB2);
    tick();
    check("bp_b2", 32'(dout), 32'hB2);
    check("bp_b2_last", 32'(dout_last), 32'h1);
    clear_all();
    tick();
    check("bp_drain", 32'(dout_valid), 32'h0);

    // Enable low: locked packet on channel 1 finishes, channel 3 waits
    set_ch(1, 1, 0, 8'hC0);
    tick();
    check("en_c0", 32'(dout), 32'hC0);
    en = 1'b0;
    set_ch(1, 1, 1, 8'hC1);
    set_ch(3, 1, 1, 8'hD0);
    tick();
    check("en_c1", 32'(dout), 32'hC1);
    set_ch(1, 0, 0, 8'h00);
    for (int n = 0; n < 2; n++) begin
      #1 check("en_rdy", 32'(rdy), 32'h0);
      tick();
      check("en_idle", 32'(dout_valid), 32'h0);
    end
    en = 1'b1;
    tick();
    check("en_d0", 32'(dout), 32'hD0);
    check("en_d0_sel", 32'(dsel), 32'h3);

    // Reset in the middle of a channel 3 packet
    clear_all();
    set_ch(3, 1, 0, 8'hE0);
    tick();
    check("mr_e0", 32'(dout), 32'hE0);
    set_ch(3, 1, 0, 8'hE1);
    rst = 1'b1;
    tick();
    check("mr_valid", 32'(dout_valid), 32'h0);
    rst = 1'b0;
    set_ch(1, 1, 1, 8'h11);
    tick();
    check("mr_sel", 32'(dsel), 32'h1);
    check("mr_out", 32'(dout), 32'h11);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      din        = $urandom;
      dvalid     = 4'($urandom);
      dlast      = 4'($urandom);
      en         = ($urandom % 8) != 0;
      dout_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 200) == 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
